// File: rtl/dvp_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pixel_packer
//  Purpose  : Packs DVP byte pairs into 16-bit RGB565 pixels and tags each
//             pixel with x/y coordinates plus start-of-frame / end-of-line.
//             Detects malformed lines and premature frame starts.
//  Ports    : clk, rst (sync, active-high)
//             capture_en, vsync_rise, href, d[7:0]      - inputs
//             pixel[15:0], pixel_valid, pix_x, pix_y,
//             sof, eol                                  - pixel stream
//             frame_done, line_err, frame_err, busy     - status
//             frame_cnt[15:0], err_cnt[7:0]             - only with
//                                                         DVP_PIXEL_PACKER_STATS_EN
//  Options  : `define DVP_PIXEL_PACKER_STATS_EN adds frame/error counters.
//  Revision : 1.0 - initial release
// ============================================================================
module dvp_pixel_packer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BYTE_ORDER = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        capture_en,
    input  logic                        vsync_rise,
    input  logic                        href,
    input  logic [7:0]                  d,
    output logic [15:0]                 pixel,
    output logic                        pixel_valid,
    output logic [$clog2(H_ACTIVE)-1:0] pix_x,
    output logic [$clog2(V_ACTIVE)-1:0] pix_y,
    output logic                        sof,
    output logic                        eol,
    output logic                        frame_done,
    output logic                        line_err,
    output logic                        frame_err,
    output logic                        busy
`ifdef DVP_PIXEL_PACKER_STATS_EN
    ,
    output logic [15:0]                 frame_cnt,
    output logic [7:0]                  err_cnt
`endif
);

    localparam int c_XW  = $clog2(H_ACTIVE);
    localparam int c_YW  = $clog2(V_ACTIVE);
    // Internal counters must be able to hold H_ACTIVE / V_ACTIVE themselves.
    localparam int c_XCW = $clog2(H_ACTIVE + 1);
    localparam int c_YCW = $clog2(V_ACTIVE + 1);

    localparam logic [c_XCW-1:0] c_X_END  = c_XCW'(H_ACTIVE);
    localparam logic [c_XCW-1:0] c_X_LAST = c_XCW'(H_ACTIVE - 1);
    localparam logic [c_XCW-1:0] c_X_ONE  = c_XCW'(1);
    localparam logic [c_YCW-1:0] c_Y_END  = c_YCW'(V_ACTIVE);
    localparam logic [c_YCW-1:0] c_Y_ONE  = c_YCW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FRAME = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_XCW-1:0]  r_x;
    logic [c_YCW-1:0]  r_y;
    logic              r_phase;
    logic              r_in_line;   // at least one byte seen since last line end
    logic              r_dropped;   // bytes discarded past H_ACTIVE on this line
    logic [7:0]        r_first;
    logic [15:0]       r_pixel;
    logic              r_pixel_valid;
    logic [c_XW-1:0]   r_pix_x;
    logic [c_YW-1:0]   r_pix_y;
    logic              r_sof;
    logic              r_eol;
    logic              r_frame_done;
    logic              r_line_err;
    logic              r_frame_err;

    logic              w_line_end;
    logic              w_line_bad;
    logic [c_YCW-1:0]  w_y_next;
    logic              w_last_line;

    // A line ends on the first href=0 cycle after bytes were taken in FRAME;
    // tracking r_in_line avoids a spurious line end right after frame start.
    assign w_line_end  = (r_state == S_FRAME) && !href && r_in_line;
    assign w_line_bad  = (r_x != c_X_END) || r_phase || r_dropped;
    assign w_y_next    = (r_y == c_Y_END) ? r_y : (r_y + c_Y_ONE);
    assign w_last_line = (w_y_next == c_Y_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_phase       <= 1'b0;
            r_in_line     <= 1'b0;
            r_dropped     <= 1'b0;
            r_first       <= 8'h00;
            r_pixel       <= 16'h0000;
            r_pixel_valid <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_sof         <= 1'b0;
            r_eol         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_sof         <= 1'b0;
            r_eol         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (capture_en) begin
                        r_state <= S_ARMED;
                    end
                end

                S_ARMED: begin
                    if (vsync_rise) begin
                        r_state   <= S_FRAME;
                        r_x       <= '0;
                        r_y       <= '0;
                        r_phase   <= 1'b0;
                        r_in_line <= 1'b0;
                        r_dropped <= 1'b0;
                    end
                end

                S_FRAME: begin
                    if (w_line_end) begin
                        r_line_err <= w_line_bad;
                        r_x        <= '0;
                        r_phase    <= 1'b0;
                        r_in_line  <= 1'b0;
                        r_dropped  <= 1'b0;
                        r_y        <= w_y_next;
                        if (w_last_line) begin
                            // Frame completion wins over a coincident vsync;
                            // that vsync only starts a new frame when armed.
                            r_frame_done <= 1'b1;
                            if (!capture_en) begin
                                r_state <= S_IDLE;
                            end else if (vsync_rise) begin
                                r_y <= '0;
                            end else begin
                                r_state <= S_ARMED;
                            end
                        end else if (vsync_rise) begin
                            r_frame_err <= 1'b1;
                            r_y         <= '0;
                        end
                    end else if (vsync_rise) begin
                        r_frame_err <= 1'b1;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_phase     <= 1'b0;
                        r_in_line   <= 1'b0;
                        r_dropped   <= 1'b0;
                    end else if (href) begin
                        r_in_line <= 1'b1;
                        if (r_x == c_X_END) begin
                            r_dropped <= 1'b1;
                        end else if (!r_phase) begin
                            r_first <= d;
                            r_phase <= 1'b1;
                        end else begin
                            r_pixel       <= (BYTE_ORDER == 0) ? {r_first, d} : {d, r_first};
                            r_pixel_valid <= 1'b1;
                            r_pix_x       <= r_x[c_XW-1:0];
                            r_pix_y       <= r_y[c_YW-1:0];
                            r_sof         <= (r_x == '0) && (r_y == '0);
                            r_eol         <= (r_x == c_X_LAST);
                            r_x           <= r_x + c_X_ONE;
                            r_phase       <= 1'b0;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pixel       = r_pixel;
    assign pixel_valid = r_pixel_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign sof         = r_sof;
    assign eol         = r_eol;
    assign frame_done  = r_frame_done;
    assign line_err    = r_line_err;
    assign frame_err   = r_frame_err;
    assign busy        = (r_state == S_ARMED) || (r_state == S_FRAME);

`ifdef DVP_PIXEL_PACKER_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_err_cnt;

    // Counters follow the registered pulses, so they trail them by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 16'h0000;
            r_err_cnt   <= 8'h00;
        end else begin
            if (r_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if ((r_line_err || r_frame_err) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dvp_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dvp_pixel_packer
//  Purpose  : Directed self-checking bench for dvp_pixel_packer with
//             H_ACTIVE=4, V_ACTIVE=2, BYTE_ORDER=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dvp_pixel_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        capture_en;
    logic        vsync_rise;
    logic        href;
    logic [7:0]  d;
    logic [15:0] pixel;
    logic        pixel_valid;
    logic [1:0]  pix_x;
    logic [0:0]  pix_y;
    logic        sof;
    logic        eol;
    logic        frame_done;
    logic        line_err;
    logic        frame_err;
    logic        busy;
`ifdef DVP_PIXEL_PACKER_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [15:0] p;
        logic [1:0]  x;
        logic [0:0]  y;
        logic        sof;
        logic        eol;
    } pix_t;

    pix_t q[$];
    int   n_fd = 0;
    int   n_le = 0;
    int   n_fe = 0;

    dvp_pixel_packer #(
        .H_ACTIVE  (4),
        .V_ACTIVE  (2),
        .BYTE_ORDER(0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .capture_en (capture_en),
        .vsync_rise (vsync_rise),
        .href       (href),
        .d          (d),
        .pixel      (pixel),
        .pixel_valid(pixel_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .sof        (sof),
        .eol        (eol),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef DVP_PIXEL_PACKER_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Collect the pixel stream and pulses on the falling edge.
    always @(negedge clk) begin
        if (pixel_valid) q.push_back('{p: pixel, x: pix_x, y: pix_y, sof: sof, eol: eol});
        if (frame_done) n_fd++;
        if (line_err)   n_le++;
        if (frame_err)  n_fe++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        q.delete();
        n_fd = 0;
        n_le = 0;
        n_fe = 0;
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            href = 1'b1;
            d    = base + 8'(i);
            cyc();
        end
    endtask

    // Drives the href fall; caller samples the resulting pulses right after.
    task automatic line_end();
        href = 1'b0;
        d    = 8'h00;
        cyc();
    endtask

    task automatic check_pix(input int i, input logic [15:0] p, input int x, input int y,
                             input logic s, input logic e);
        logic [1:0] xe;
        logic [0:0] ye;
        xe = 2'(x);
        ye = 1'(y);
        if (i >= q.size()) begin
            chk($sformatf("pix%0d_present", i), q.size(), i + 1);
        end else begin
            chk($sformatf("pix%0d_data", i), q[i].p, p);
            chk($sformatf("pix%0d_tag", i), {q[i].x, q[i].y, q[i].sof, q[i].eol}, {xe, ye, s, e});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; capture_en = 1'b0; vsync_rise = 1'b0; href = 1'b0; d = 8'h00;
        cyc(); cyc();
        chk("rst_pixel", pixel, 16'h0000);
        chk("rst_outs", {pixel_valid, sof, eol, frame_done, line_err, frame_err, busy}, 7'b0);
        chk("rst_xy", {pix_x, pix_y}, 3'b0);
        rst = 1'b0;
        cyc();
        chk("idle_busy", busy, 1'b0);

        // ---- Nominal frame ----
        capture_en = 1'b1;
        cyc();
        chk("armed_busy", busy, 1'b1);
        clear();
        vsync_rise = 1'b1; cyc(); vsync_rise = 1'b0;
        for (int i = 0; i < 8; i++) begin
            href = 1'b1;
            d    = 8'(i);
            cyc();
            chk($sformatf("nom_lat%0d", i), pixel_valid, 32'(i % 2));
        end
        line_end();
        chk("nom_l1_err", line_err, 1'b0);
        chk("nom_l1_fd", frame_done, 1'b0);
        cyc();
        send_bytes(8, 8'h00);
        line_end();
        chk("nom_fd", frame_done, 1'b1);
        cyc();
        chk("nom_fd_1cyc", frame_done, 1'b0);
        chk("nom_cnt", q.size(), 8);
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 4; k++) begin
                check_pix(l * 4 + k, {8'(2 * k), 8'(2 * k + 1)}, k, l,
                          (k == 0 && l == 0), (k == 3));
            end
        end
        chk("nom_pulses", {n_fd[7:0], n_le[7:0], n_fe[7:0]}, {8'd1, 8'd0, 8'd0});
        chk("nom_rearm", busy, 1'b1);

        // ---- Short/odd line ----
        clear();
        vsync_rise = 1'b1; cyc(); vsync_rise = 1'b0;
        send_bytes(7, 8'h10);
        line_end();
        chk("short_lerr", line_err, 1'b1);
        cyc();
        send_bytes(8, 8'h20);
        line_end();
        chk("short_fd", frame_done, 1'b1);
        cyc();
        chk("short_cnt", q.size(), 7);
        check_pix(0, 16'h1011, 0, 0, 1'b1, 1'b0);
        check_pix(2, 16'h1415, 2, 0, 1'b0, 1'b0);
        check_pix(3, 16'h2021, 0, 1, 1'b0, 1'b0);
        check_pix(6, 16'h2627, 3, 1, 1'b0, 1'b1);
        chk("short_nle", n_le, 1);

        // ---- Long line, then premature vsync ----
        clear();
        vsync_rise = 1'b1; cyc(); vsync_rise = 1'b0;
        send_bytes(10, 8'h30);
        line_end();
        chk("long_lerr", line_err, 1'b1);
        cyc();
        chk("long_cnt", q.size(), 4);
        check_pix(3, 16'h3637, 3, 0, 1'b0, 1'b1);
        vsync_rise = 1'b1; cyc(); vsync_rise = 1'b0;
        chk("pre_ferr", frame_err, 1'b1);
        chk("pre_nofd", frame_done, 1'b0);
        send_bytes(8, 8'h40);
        line_end();
        cyc();
        check_pix(4, 16'h4041, 0, 0, 1'b1, 1'b0);
        send_bytes(8, 8'h50);
        line_end();
        chk("pre_fd", frame_done, 1'b1);
        cyc();
        chk("pre_cnt", q.size(), 12);
        check_pix(11, 16'h5657, 3, 1, 1'b0, 1'b1);
        chk("pre_pulses", {n_fd[7:0], n_le[7:0], n_fe[7:0]}, {8'd1, 8'd1, 8'd1});

        // ---- Disarm mid-frame ----
        clear();
        vsync_rise = 1'b1; cyc(); vsync_rise = 1'b0;
        send_bytes(4, 8'h60);
        capture_en = 1'b0;
        send_bytes(4, 8'h64);
        line_end();
        cyc();
        send_bytes(8, 8'h70);
        line_end();
        chk("dis_fd", frame_done, 1'b1);
        chk("dis_busy", busy, 1'b0);
        cyc();
        vsync_rise = 1'b1; cyc(); vsync_rise = 1'b0;
        send_bytes(8, 8'h80);
        line_end();
        cyc();
        chk("dis_cnt", q.size(), 8);
        check_pix(7, 16'h7677, 3, 1, 1'b0, 1'b1);
        chk("dis_busy2", busy, 1'b0);
`ifdef DVP_PIXEL_PACKER_STATS_EN
        chk("stat_frames", frame_cnt, 16'd4);
        chk("stat_errs", err_cnt, 8'd3);
`endif

        // ---- Reset mid-line ----
        clear();
        capture_en = 1'b1;
        cyc();
        vsync_rise = 1'b1; cyc(); vsync_rise = 1'b0;
        send_bytes(3, 8'h90);
        chk("rml_pix", pixel, 16'h9091);
        rst  = 1'b1;
        href = 1'b1;
        d    = 8'h93;
        cyc();
        chk("rml_pixel", pixel, 16'h0000);
        chk("rml_outs", {pixel_valid, sof, eol, frame_done, line_err, frame_err, busy}, 7'b0);
`ifdef DVP_PIXEL_PACKER_STATS_EN
        chk("rml_stats", {frame_cnt, err_cnt}, 24'h0);
`endif
        rst  = 1'b0;
        href = 1'b0;
        cyc(); cyc();
        chk("rml_nopulse", {n_fd[7:0], n_le[7:0], n_fe[7:0]}, 24'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dvp_pixel_packer.md
Name: dvp_pixel_packer

Overview:
- Consumes the single-cycle VSYNC rising-edge pulse from the edge-capture stage, plus the camera HREF level and the 8-bit DVP data bus.
- Assembles byte pairs into 16-bit RGB565 pixels and tags each pixel with x/y coordinates, start-of-frame and end-of-line markers.
- Sits between the OV5640 DVP input registers and the pixel FIFO/stream writer. Runs entirely in the camera pixel clock domain.

Parameters:
- H_ACTIVE, 640, pixels per line (16-bit pixels, so 2*H_ACTIVE bytes while href=1).
- V_ACTIVE, 480, lines per frame.
- BYTE_ORDER, 0, 0 = first byte of pair is pixel[15:8]; 1 = first byte is pixel[7:0].

Ports:
- clk  in  1  pixel clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- capture_en  in  1  arm capture; sampled at frame boundaries.
- vsync_rise  in  1  one-cycle pulse marking frame start.
- href  in  1  line-valid level, already registered.
- d  in  8  DVP data, aligned with href.
- pixel  out  16  packed RGB565 pixel.
- pixel_valid  out  1  one-cycle qualifier for pixel/pix_x/pix_y/sof/eol.
- pix_x  out  $clog2(H_ACTIVE)  column of current pixel.
- pix_y  out  $clog2(V_ACTIVE)  row of current pixel.
- sof  out  1  high with first pixel of frame (x=0,y=0).
- eol  out  1  high with pixel x=H_ACTIVE-1.
- frame_done  out  1  one-cycle pulse after last line of frame ends.
- line_err  out  1  one-cycle pulse on malformed line.
- frame_err  out  1  one-cycle pulse on premature vsync_rise.
- busy  out  1  high in ARMED or FRAME.

Behaviour:
- Reset (rst=1 on a clk edge): state=IDLE; byte phase=0; x=y=0. All outputs 0, including pixel=16'h0000. rst overrides every other input and aborts an in-progress frame without asserting frame_done or any error pulse.
- State IDLE: goes to ARMED when capture_en=1.
- State ARMED: waits for vsync_rise. On vsync_rise, goes to FRAME with x=0, y=0, phase=0. href and d are ignored in ARMED.
- State FRAME, href=1, phase=0: latch d as first byte; phase becomes 1.
- State FRAME, href=1, phase=1: form the pixel per BYTE_ORDER. pixel_valid=1 on the next cycle, so latency is 1 clk after the second byte's edge. pix_x=x, pix_y=y; then x increments and phase becomes 0.
- sof=1 only on pixel x=0, y=0. eol=1 only on pixel x=H_ACTIVE-1. Both are valid only when pixel_valid=1.
- Bytes arriving when x has reached H_ACTIVE are dropped (no pixel_valid), and the line is flagged as an error.
- Line end: first cycle with href=0 after href=1.
  - line_err pulses if x != H_ACTIVE, or phase=1 (odd byte, which is discarded), or bytes were dropped.
  - Then x=0, phase=0, y increments.
  - If the incremented y equals V_ACTIVE: frame_done pulses next cycle. State goes to ARMED if capture_en=1, else IDLE.
- vsync_rise while in FRAME: frame_err pulses; frame restarts immediately at x=y=0. No frame_done.
- vsync_rise coinciding with the cycle of the final line end: frame_done takes priority. The pulse is consumed as the next frame's start only if capture_en=1.
- capture_en deasserted mid-frame: current frame completes normally, then IDLE.
- busy=1 in ARMED or FRAME.
- pixel holds its last value when pixel_valid=0.
- Counters never wrap inside a frame; y saturates at V_ACTIVE.

Optional Feature:
- Macro: DVP_PIXEL_PACKER_STATS_EN.
- With macro defined: adds outputs frame_cnt[15:0] and err_cnt[7:0], both reset to 0.
  - frame_cnt increments on frame_done and wraps at 16'hFFFF->0.
  - err_cnt increments on line_err or frame_err and saturates at 8'hFF. Simultaneous line_err and frame_err count as one.
- Without macro: these ports do not exist and no counter logic is built. All other behaviour is identical.

Test Plan:
All tests use H_ACTIVE=4, V_ACTIVE=2, BYTE_ORDER=0.
- Nominal frame: capture_en=1; vsync_rise; two lines of 8 bytes 8'h00..8'h07 with 2 idle href=0 cycles between lines. Expect pixels 16'h0001, 16'h0203, 16'h0405, 16'h0607 per line, each 1 clk after its second byte; sof on the first only; eol on x=3; frame_done 1 cycle after line-2 href fall; no errors.
- Short/odd line: line of 7 bytes. Expect 3 pixels, no eol, line_err pulse at line end, y still advances.
- Long line: 10 bytes. Expect exactly 4 pixels, last two bytes dropped, line_err=1.
- Premature vsync: vsync_rise after line 1. Expect frame_err pulse, no frame_done; next pixel has sof=1, pix_y=0.
- Disarm mid-frame: drop capture_en during line 1. Frame completes with frame_done; state goes to IDLE; busy=0; a subsequent vsync_rise produces no pixels.
- Reset mid-line, after 3 bytes: all outputs 0 next cycle; no frame_done. With DVP_PIXEL_PACKER_STATS_EN, frame_cnt=0 and err_cnt=0 after reset.
